// File: rtl/z88_ps2_keymatrix.sv
// PS/2 set-2 receiver and decoder feeding the Z88 Blink keyboard matrix.
// kb_matrix bit = col*8 + row, col n on A(8+n), row = data bit, 1 = pressed.
module z88_ps2_keymatrix #(
  parameter int FILT_LEN = 8,
  parameter int TMO_CYC  = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [63:0] kb_matrix,
  output logic [7:0]  scan_code,
  output logic        scan_vld,
  output logic        frm_err
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic [FW-1:0] clk_fcnt;
  logic [FW-1:0] dat_fcnt;
  logic          clk_filt;
  logic          clk_filt_q;
  logic          dat_filt;
  logic          strobe;

  state_t        state;
  state_t        nstate;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          stop_ok;
  logic          shift_en;
  logic          par_en;
  logic          cnt_clr;
  logic          frame_ok;
  logic          frame_bad;

  logic          ext;
  logic          brk;
  logic [2:0]    skip_cnt;
  logic          map_hit;
  logic [5:0]    map_idx;
  logic          is_e1;
  logic          is_e0;
  logic          is_f0;
  logic          is_aa;
  logic          is_ign;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // A level is accepted only after FILT_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt <= 1'b1;
      clk_fcnt <= '0;
    end else if (clk_sync[1] == clk_filt) begin
      clk_fcnt <= '0;
    end else if (clk_fcnt == FW'(FILT_LEN - 1)) begin
      clk_filt <= clk_sync[1];
      clk_fcnt <= '0;
    end else begin
      clk_fcnt <= clk_fcnt + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dat_filt <= 1'b1;
      dat_fcnt <= '0;
    end else if (dat_sync[1] == dat_filt) begin
      dat_fcnt <= '0;
    end else if (dat_fcnt == FW'(FILT_LEN - 1)) begin
      dat_filt <= dat_sync[1];
      dat_fcnt <= '0;
    end else begin
      dat_fcnt <= dat_fcnt + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) clk_filt_q <= 1'b1;
    else     clk_filt_q <= clk_filt;
  end

  assign strobe  = clk_filt_q & ~clk_filt;
  assign tmo_hit = (state != S_IDLE) && !strobe &&
                   (tmo_cnt == TW'(TMO_CYC));
  assign stop_ok = dat_filt && (^{shreg, par_bit});

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (tmo_hit) begin
      nstate = S_IDLE;
    end else if (strobe) begin
      unique case (state)
        S_IDLE: if (!dat_filt) nstate = S_DATA;
        S_DATA: if (bit_cnt == 3'd7) nstate = S_PAR;
        S_PAR:  nstate = S_STOP;
        S_STOP: nstate = S_IDLE;
        default: nstate = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_clr   = strobe && (state == S_IDLE);
    shift_en  = strobe && (state == S_DATA);
    par_en    = strobe && (state == S_PAR);
    frame_ok  = strobe && (state == S_STOP) && stop_ok;
    frame_bad = (strobe && (state == S_STOP) && !stop_ok)
                || tmo_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      tmo_cnt   <= '0;
      scan_code <= '0;
      scan_vld  <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      scan_vld <= frame_ok;
      frm_err  <= frame_bad;
      if (frame_ok) scan_code <= shreg;
      if (state == S_IDLE || strobe) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + TW'(1);
      if (cnt_clr) bit_cnt <= '0;
      if (shift_en) begin
        shreg   <= {dat_filt, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (par_en) par_bit <= dat_filt;
    end
  end

  always_comb begin
    is_e1  = (scan_code == 8'hE1);
    is_e0  = (scan_code == 8'hE0);
    is_f0  = (scan_code == 8'hF0);
    is_aa  = (scan_code == 8'hAA);
    is_ign = (scan_code == 8'h00) || (scan_code == 8'hEE) ||
             (scan_code == 8'hFA) || (scan_code == 8'hFC) ||
             (scan_code == 8'hFE) || (scan_code == 8'hFF);
  end

  // {ext, code} -> matrix bit; arrows and keypad enter need the E0 prefix
  always_comb begin
    map_hit = 1'b1;
    map_idx = 6'd0;
    unique case ({ext, scan_code})
      9'h066: map_idx = 6'd7;
      9'h05A: map_idx = 6'd6;
      9'h15A: map_idx = 6'd6;
      9'h036: map_idx = 6'd5;
      9'h035: map_idx = 6'd4;
      9'h033: map_idx = 6'd3;
      9'h031: map_idx = 6'd2;
      9'h03D: map_idx = 6'd1;
      9'h03E: map_idx = 6'd0;
      9'h05D: map_idx = 6'd15;
      9'h175: map_idx = 6'd14;
      9'h02E: map_idx = 6'd13;
      9'h02C: map_idx = 6'd12;
      9'h034: map_idx = 6'd11;
      9'h032: map_idx = 6'd10;
      9'h03C: map_idx = 6'd9;
      9'h043: map_idx = 6'd8;
      9'h055: map_idx = 6'd23;
      9'h172: map_idx = 6'd22;
      9'h025: map_idx = 6'd21;
      9'h02D: map_idx = 6'd20;
      9'h02B: map_idx = 6'd19;
      9'h02A: map_idx = 6'd18;
      9'h03B: map_idx = 6'd17;
      9'h044: map_idx = 6'd16;
      9'h04E: map_idx = 6'd31;
      9'h174: map_idx = 6'd30;
      9'h026: map_idx = 6'd29;
      9'h024: map_idx = 6'd28;
      9'h023: map_idx = 6'd27;
      9'h021: map_idx = 6'd26;
      9'h042: map_idx = 6'd25;
      9'h046: map_idx = 6'd24;
      9'h05B: map_idx = 6'd39;
      9'h16B: map_idx = 6'd38;
      9'h01E: map_idx = 6'd37;
      9'h01D: map_idx = 6'd36;
      9'h01B: map_idx = 6'd35;
      9'h022: map_idx = 6'd34;
      9'h03A: map_idx = 6'd33;
      9'h04D: map_idx = 6'd32;
      9'h054: map_idx = 6'd47;
      9'h029: map_idx = 6'd46;
      9'h016: map_idx = 6'd45;
      9'h015: map_idx = 6'd44;
      9'h01C: map_idx = 6'd43;
      9'h01A: map_idx = 6'd42;
      9'h04B: map_idx = 6'd41;
      9'h045: map_idx = 6'd40;
      9'h005: map_idx = 6'd55;
      9'h012: map_idx = 6'd54;
      9'h00D: map_idx = 6'd53;
      9'h014: map_idx = 6'd52;
      9'h114: map_idx = 6'd52;
      9'h004: map_idx = 6'd51;
      9'h041: map_idx = 6'd50;
      9'h04C: map_idx = 6'd49;
      9'h052: map_idx = 6'd48;
      9'h059: map_idx = 6'd63;
      9'h011: map_idx = 6'd62;
      9'h076: map_idx = 6'd61;
      9'h006: map_idx = 6'd60;
      9'h058: map_idx = 6'd59;
      9'h049: map_idx = 6'd58;
      9'h04A: map_idx = 6'd57;
      9'h00E: map_idx = 6'd56;
      default: map_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kb_matrix <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      skip_cnt  <= '0;
    end else if (scan_vld) begin
      if (skip_cnt != 3'd0) begin
        skip_cnt <= skip_cnt - 3'd1;
      end else begin
        unique case (1'b1)
          is_e1: skip_cnt <= 3'd7;
          is_e0: ext <= 1'b1;
          is_f0: brk <= 1'b1;
          is_aa: begin
            kb_matrix <= '0;
            ext       <= 1'b0;
            brk       <= 1'b0;
          end
          is_ign: begin
          end
          default: begin
            if (map_hit) kb_matrix[map_idx] <= ~brk;
            ext <= 1'b0;
            brk <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_z88_ps2_keymatrix.sv
// Bench for z88_ps2_keymatrix: bit-banged PS/2 frames, scoreboard of
// expected scan codes, and matrix checks after each key sequence.
module tb_z88_ps2_keymatrix;

  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2_clk;
  logic        ps2_data;
  logic [63:0] kb_matrix;
  logic [7:0]  scan_code;
  logic        scan_vld;
  logic        frm_err;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          frm_seen = 0;
  int          vld_seen = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;

  z88_ps2_keymatrix #(
    .FILT_LEN(8),
    .TMO_CYC (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kb_matrix(kb_matrix),
    .scan_code(scan_code),
    .scan_vld (scan_vld),
    .frm_err  (frm_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b0 && scan_vld === 1'b1) begin
      vld_seen++;
      vec_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL scan_vld_unexpected: got %02h, none expected",
                 scan_code);
      end else begin
        mon_exp = exp_q.pop_front();
        if (scan_code !== mon_exp) begin
          err_cnt++;
          $display("FAIL scan_code: got %02h, expected %02h",
                   scan_code, mon_exp);
        end
      end
    end
    if (rst === 1'b0 && frm_err === 1'b1) frm_seen++;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code,
                            input logic bad_par,
                            input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit((~^code) ^ bad_par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    cyc(60);
  endtask

  task automatic send_good(input logic [7:0] code);
    exp_q.push_back(code);
    send_frame(code, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    cyc(5);
    vec_cnt++;
    if (kb_matrix !== 64'd0) begin
      err_cnt++;
      $display("FAIL reset_kb: got %016h, expected 0", kb_matrix);
    end
    vec_cnt++;
    if (scan_code !== 8'h00) begin
      err_cnt++;
      $display("FAIL reset_code: got %02h, expected 00", scan_code);
    end
    vec_cnt++;
    if ({scan_vld, frm_err} !== 2'b00) begin
      err_cnt++;
      $display("FAIL reset_pulses: got %b, expected 00",
               {scan_vld, frm_err});
    end
    rst = 1'b0;
    cyc(5);
  endtask

  task automatic test_reset_midframe;
    int f0;
    f0 = frm_seen;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_data = 1'b1;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(TMO + 100);
    send_good(8'h1C);
    vec_cnt++;
    if (kb_matrix !== (64'd1 << 43) || frm_seen != f0) begin
      err_cnt++;
      $display("FAIL reset_midframe: got %016h err %0d, expected %016h err 0",
               kb_matrix, frm_seen - f0, 64'd1 << 43);
    end
    send_good(8'hF0);
    send_good(8'h1C);
  endtask

  task automatic test_make_break;
    send_good(8'h1C);
    vec_cnt++;
    if (kb_matrix !== 64'h0000_0800_0000_0000) begin
      err_cnt++;
      $display("FAIL make_a: got %016h, expected 0000080000000000",
               kb_matrix);
    end
    send_good(8'hF0);
    send_good(8'h1C);
    vec_cnt++;
    if (kb_matrix !== 64'd0) begin
      err_cnt++;
      $display("FAIL break_a: got %016h, expected 0", kb_matrix);
    end
  endtask

  task automatic test_extended;
    send_good(8'hE0);
    send_good(8'h75);
    vec_cnt++;
    if (kb_matrix !== (64'd1 << 14)) begin
      err_cnt++;
      $display("FAIL up_make: got %016h, expected %016h",
               kb_matrix, 64'd1 << 14);
    end
    send_good(8'h75);
    vec_cnt++;
    if (kb_matrix !== (64'd1 << 14)) begin
      err_cnt++;
      $display("FAIL kp8_unmapped: got %016h, expected %016h",
               kb_matrix, 64'd1 << 14);
    end
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);
    vec_cnt++;
    if (kb_matrix !== 64'd0) begin
      err_cnt++;
      $display("FAIL up_break: got %016h, expected 0", kb_matrix);
    end
  endtask

  task automatic test_multi_aa;
    logic [63:0] e;
    send_good(8'h12);
    send_good(8'h59);
    send_good(8'h5A);
    e = (64'd1 << 54) | (64'd1 << 63) | (64'd1 << 6);
    vec_cnt++;
    if (kb_matrix !== e) begin
      err_cnt++;
      $display("FAIL shifts_enter: got %016h, expected %016h",
               kb_matrix, e);
    end
    send_good(8'hAA);
    vec_cnt++;
    if (kb_matrix !== 64'd0) begin
      err_cnt++;
      $display("FAIL aa_clear: got %016h, expected 0", kb_matrix);
    end
    send_good(8'hE0);
    send_good(8'hAA);
    send_good(8'h75);
    vec_cnt++;
    if (kb_matrix !== 64'd0) begin
      err_cnt++;
      $display("FAIL aa_clears_ext: got %016h, expected 0", kb_matrix);
    end
    send_good(8'hF0);
    send_good(8'hAA);
    send_good(8'h1C);
    vec_cnt++;
    if (kb_matrix !== (64'd1 << 43)) begin
      err_cnt++;
      $display("FAIL aa_clears_brk: got %016h, expected %016h",
               kb_matrix, 64'd1 << 43);
    end
    send_good(8'hF0);
    send_good(8'hFA);
    send_good(8'h1C);
    vec_cnt++;
    if (kb_matrix !== 64'd0) begin
      err_cnt++;
      $display("FAIL ignored_keeps_brk: got %016h, expected 0", kb_matrix);
    end
  endtask

  task automatic test_parity;
    int f0;
    int v0;
    f0 = frm_seen;
    v0 = vld_seen;
    send_frame(8'h29, 1'b1, 1'b0);
    vec_cnt++;
    if (frm_seen - f0 != 1 || vld_seen != v0 || kb_matrix[46] !== 1'b0) begin
      err_cnt++;
      $display("FAIL bad_parity: got err %0d vld %0d bit46 %b, expected 1 0 0",
               frm_seen - f0, vld_seen - v0, kb_matrix[46]);
    end
    send_good(8'h29);
    vec_cnt++;
    if (kb_matrix !== (64'd1 << 46)) begin
      err_cnt++;
      $display("FAIL space_resend: got %016h, expected %016h",
               kb_matrix, 64'd1 << 46);
    end
    f0 = frm_seen;
    send_frame(8'h1C, 1'b0, 1'b1);
    vec_cnt++;
    if (frm_seen - f0 != 1 || kb_matrix !== (64'd1 << 46)) begin
      err_cnt++;
      $display("FAIL bad_stop: got err %0d kb %016h, expected 1 %016h",
               frm_seen - f0, kb_matrix, 64'd1 << 46);
    end
    send_good(8'hF0);
    send_good(8'h29);
  endtask

  task automatic test_timeout;
    int f0;
    f0 = frm_seen;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    ps2_data = 1'b1;
    cyc(TMO + 200);
    vec_cnt++;
    if (frm_seen - f0 != 1) begin
      err_cnt++;
      $display("FAIL timeout_err: got %0d pulses, expected 1", frm_seen - f0);
    end
    send_good(8'h29);
    vec_cnt++;
    if (kb_matrix !== (64'd1 << 46) || frm_seen - f0 != 1) begin
      err_cnt++;
      $display("FAIL after_timeout: got %016h err %0d, expected %016h err 1",
               kb_matrix, frm_seen - f0, 64'd1 << 46);
    end
    send_good(8'hF0);
    send_good(8'h29);
  endtask

  task automatic test_pause;
    logic [7:0] seq [9];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
    for (int i = 0; i < 9; i++) send_good(seq[i]);
    vec_cnt++;
    if (kb_matrix !== (64'd1 << 43)) begin
      err_cnt++;
      $display("FAIL pause_skip: got %016h, expected %016h",
               kb_matrix, 64'd1 << 43);
    end
    send_good(8'hAA);
  endtask

  task automatic test_glitch;
    int f0;
    int v0;
    f0 = frm_seen;
    v0 = vld_seen;
    ps2_data = 1'b0;
    cyc(30);
    for (int w = 1; w < 7; w++) begin
      ps2_clk = 1'b0;
      cyc(w);
      ps2_clk = 1'b1;
      cyc(20);
    end
    ps2_data = 1'b1;
    cyc(TMO + 200);
    vec_cnt++;
    if (frm_seen != f0 || vld_seen != v0 || kb_matrix !== 64'd0) begin
      err_cnt++;
      $display("FAIL glitch: got err %0d vld %0d kb %016h, expected 0 0 0",
               frm_seen - f0, vld_seen - v0, kb_matrix);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] e;
    send_good(8'h29);
    send_good(8'h1C);
    send_good(8'h1C);
    send_good(8'hE0);
    send_good(8'h14);
    send_good(8'h05);
    send_good(8'h0E);
    e = (64'd1 << 46) | (64'd1 << 43) | (64'd1 << 52) |
        (64'd1 << 55) | (64'd1 << 56);
    vec_cnt++;
    if (kb_matrix !== e) begin
      err_cnt++;
      $display("FAIL typematic_mix: got %016h, expected %016h",
               kb_matrix, e);
    end
    send_good(8'hF0);
    send_good(8'h1C);
    send_good(8'hF0);
    send_good(8'h14);
    e = (64'd1 << 46) | (64'd1 << 55) | (64'd1 << 56);
    vec_cnt++;
    if (kb_matrix !== e) begin
      err_cnt++;
      $display("FAIL break_keeps_others: got %016h, expected %016h",
               kb_matrix, e);
    end
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_drain: got %0d left, expected 0",
               exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_multi_aa();
    test_parity();
    test_timeout();
    test_pause();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
